arp_sequencer: RTL and testbench

//  Parametrised N-key arpeggiator; successor to the fixed 4-key arpeggiator in the synth top.

---
 rtl/arp_sequencer.sv | 177 +++++++++++++++++
 tb/tb_arp_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/arp_sequencer.sv
// N-key arpeggiator: steps through the held keys (up, down, ping-pong) and
// drives exactly one voice key_on per step; passes keys straight through when disabled.
module arp_sequencer #(
  parameter int NUM_KEYS = 8,
  parameter int CNT_W    = 16,
  parameter int IDX_W    = $clog2(NUM_KEYS)
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [CNT_W-1:0]    step_time,
  input  logic [NUM_KEYS-1:0] keys_in,
  output logic [NUM_KEYS-1:0] keys_out,
  output logic [IDX_W-1:0]    cur_idx,
  output logic                step_pulse
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic       DIR_UP    = 1'b0;
  localparam logic       DIR_DOWN  = 1'b1;

  state_t             state;
  logic [CNT_W-1:0]   counter;
  logic               dir;

  logic [NUM_KEYS-1:0] above;
  logic [NUM_KEYS-1:0] below;
  logic [IDX_W-1:0]    next_idx;
  logic                next_dir;
  logic [IDX_W-1:0]    start_idx;
  logic                advance;

  function automatic logic [IDX_W-1:0] lowest(input logic [NUM_KEYS-1:0] k);
    lowest = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (k[i]) begin
        lowest = IDX_W'(i);
      end
    end
  endfunction

  function automatic logic [IDX_W-1:0] highest(input logic [NUM_KEYS-1:0] k);
    highest = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (k[i]) begin
        highest = IDX_W'(i);
      end
    end
  endfunction

  function automatic logic [NUM_KEYS-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Split the held keys into those above and below the current index, then pick the successor.
  always_comb begin
    above    = '0;
    below    = '0;
    next_idx = cur_idx;
    next_dir = dir;
    for (int i = 0; i < NUM_KEYS; i++) begin
      above[i] = keys_in[i] && (i > int'(cur_idx));
      below[i] = keys_in[i] && (i < int'(cur_idx));
    end
    case (mode)
      MODE_DOWN: begin
        if (|below) begin
          next_idx = highest(below);
        end else if (|above) begin
          next_idx = highest(above);
        end else begin
          next_idx = cur_idx;
        end
      end
      MODE_PP: begin
        // No wrap: bounce at the ends so endpoints sound only once per sweep.
        if (dir == DIR_UP) begin
          if (|above) begin
            next_idx = lowest(above);
          end else if (|below) begin
            next_idx = highest(below);
            next_dir = DIR_DOWN;
          end else begin
            next_idx = cur_idx;
          end
        end else begin
          if (|below) begin
            next_idx = highest(below);
          end else if (|above) begin
            next_idx = lowest(above);
            next_dir = DIR_UP;
          end else begin
            next_idx = cur_idx;
          end
        end
      end
      default: begin
        if (|above) begin
          next_idx = lowest(above);
        end else if (|below) begin
          next_idx = lowest(below);
        end else begin
          next_idx = cur_idx;
        end
      end
    endcase
  end

  assign start_idx = (mode == MODE_DOWN) ? highest(keys_in) : lowest(keys_in);
  // >= rather than == so a step_time lowered below the running count still advances.
  assign advance   = (counter >= step_time) || !keys_in[cur_idx];

  // Sequencer state, step counter and all registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      counter    <= '0;
      dir        <= DIR_UP;
      cur_idx    <= '0;
      keys_out   <= '0;
      step_pulse <= 1'b0;
    end else if (!enable) begin
      state      <= IDLE;
      counter    <= '0;
      dir        <= DIR_UP;
      keys_out   <= keys_in;
      step_pulse <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          counter <= '0;
          dir     <= DIR_UP;
          if (|keys_in) begin
            state      <= RUN;
            cur_idx    <= start_idx;
            keys_out   <= onehot(start_idx);
            step_pulse <= 1'b1;
          end else begin
            keys_out   <= '0;
            step_pulse <= 1'b0;
          end
        end
        RUN: begin
          if (keys_in == '0) begin
            state      <= IDLE;
            counter    <= '0;
            keys_out   <= '0;
            step_pulse <= 1'b0;
          end else if (advance) begin
            counter    <= '0;
            cur_idx    <= next_idx;
            keys_out   <= onehot(next_idx) & keys_in;
            step_pulse <= (next_idx != cur_idx);
            dir        <= (mode == MODE_PP) ? next_dir : DIR_UP;
          end else begin
            counter    <= counter + CNT_W'(1);
            keys_out   <= onehot(cur_idx) & keys_in;
            step_pulse <= 1'b0;
            dir        <= (mode == MODE_PP) ? dir : DIR_UP;
          end
        end
        default: begin
          state      <= IDLE;
          counter    <= '0;
          keys_out   <= '0;
          step_pulse <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arp_sequencer.sv
// Self-checking bench for arp_sequencer: table of per-cycle vectors plus hand-written
// multi-cycle sequences; expectations go through a scoreboard queue.
module tb_arp_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        enable;
  logic [1:0]  mode;
  logic [15:0] step_time;
  logic [7:0]  keys_in;
  logic [7:0]  keys_out;
  logic [2:0]  cur_idx;
  logic        step_pulse;

  always #5 Clk = ~Clk;

  arp_sequencer #(.NUM_KEYS(8), .CNT_W(16)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .enable     (enable),
    .mode       (mode),
    .step_time  (step_time),
    .keys_in    (keys_in),
    .keys_out   (keys_out),
    .cur_idx    (cur_idx),
    .step_pulse (step_pulse)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        en;
    logic [1:0]  md;
    logic [15:0] st;
    logic [7:0]  keys;
    logic [7:0]  ko;
    logic [2:0]  idx;
    logic        pulse;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] ko;
    logic [2:0] idx;
    logic       pulse;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  function automatic vec_t mk(string name, bit rst, bit en, bit [1:0] md, int unsigned st,
                              bit [7:0] keys, bit [7:0] ko, int unsigned idx, bit pulse);
    vec_t v;
    v.name  = name;
    v.rst   = rst;
    v.en    = en;
    v.md    = md;
    v.st    = 16'(st);
    v.keys  = keys;
    v.ko    = ko;
    v.idx   = 3'(idx);
    v.pulse = pulse;
    return v;
  endfunction

  task automatic add(string name, bit rst, bit en, bit [1:0] md, int unsigned st,
                     bit [7:0] keys, bit [7:0] ko, int unsigned idx, bit pulse);
    tbl.push_back(mk(name, rst, en, md, st, keys, ko, idx, pulse));
  endtask

  task automatic check_out();
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      failed++;
      $display("FAIL scoreboard_empty: got output with no expectation queued");
    end else begin
      e = sb.pop_front();
      if (keys_out !== e.ko || cur_idx !== e.idx || step_pulse !== e.pulse) begin
        failed++;
        $display("FAIL %s: got keys_out=%h cur_idx=%0d step_pulse=%b, expected keys_out=%h cur_idx=%0d step_pulse=%b",
                 e.name, keys_out, cur_idx, step_pulse, e.ko, e.idx, e.pulse);
      end
    end
  endtask

  task automatic apply(vec_t v);
    exp_t e;
    Reset     = v.rst;
    enable    = v.en;
    mode      = v.md;
    step_time = v.st;
    keys_in   = v.keys;
    e.name  = v.name;
    e.ko    = v.ko;
    e.idx   = v.idx;
    e.pulse = v.pulse;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    check_out();
  endtask

  task automatic step(string name, bit rst, bit en, bit [1:0] md, int unsigned st,
                      bit [7:0] keys, bit [7:0] ko, int unsigned idx, bit pulse);
    apply(mk(name, rst, en, md, st, keys, ko, idx, pulse));
  endtask

  initial begin
    int seq2[4] = '{1, 2, 5, 1};
    int seq4[7] = '{1, 3, 5, 3, 1, 3, 5};

    Reset = 1'b1; enable = 1'b0; mode = 2'b00; step_time = 16'd0; keys_in = 8'h00;

    // reset and pass-through
    add("reset0", 1, 0, 2'b00, 0, 8'h00, 8'h00, 0, 0);
    add("reset1", 1, 1, 2'b00, 0, 8'hFF, 8'h00, 0, 0);
    add("pass_a5", 0, 0, 2'b00, 0, 8'hA5, 8'hA5, 0, 0);
    add("pass_3c", 0, 0, 2'b00, 0, 8'h3C, 8'h3C, 0, 0);
    add("pass_00", 0, 0, 2'b00, 0, 8'h00, 8'h00, 0, 0);

    // up, step_time=3, keys {1,2,5}: each key held 4 cycles, wraps back to 1
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        add("up_st3", 0, 1, 2'b00, 3, 8'h26, 8'h01 << seq2[k], seq2[k], c == 0);
      end
    end
    add("up_dis", 0, 0, 2'b00, 3, 8'h00, 8'h00, 1, 0);

    // down, step_time=0, keys {0,7}: toggles every cycle starting at the highest key
    for (int k = 0; k < 6; k++) begin
      add("down_st0", 0, 1, 2'b01, 0, 8'h81, (k % 2 == 0) ? 8'h80 : 8'h01, (k % 2 == 0) ? 7 : 0, 1);
    end
    add("down_dis", 0, 0, 2'b01, 0, 8'h00, 8'h00, 0, 0);

    // ping-pong, step_time=1, keys {1,3,5}: endpoints not repeated
    for (int k = 0; k < 7; k++) begin
      for (int c = 0; c < 2; c++) begin
        add("pp_st1", 0, 1, 2'b10, 1, 8'h2A, 8'h01 << seq4[k], seq4[k], c == 0);
      end
    end
    add("pp_dis", 0, 0, 2'b10, 1, 8'h00, 8'h00, 5, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
    end

    // release of the sounding key mid-step, then a lone key expiring, then release all
    step("rel_enter", 0, 1, 2'b00, 9, 8'h48, 8'h08, 3, 1);
    step("rel_cnt1",  0, 1, 2'b00, 9, 8'h48, 8'h08, 3, 0);
    step("rel_adv",   0, 1, 2'b00, 9, 8'h40, 8'h40, 6, 1);
    for (int c = 0; c < 9; c++) begin
      step("solo_hold", 0, 1, 2'b00, 9, 8'h40, 8'h40, 6, 0);
    end
    step("solo_expire", 0, 1, 2'b00, 9, 8'h40, 8'h40, 6, 0);
    step("solo_after",  0, 1, 2'b00, 9, 8'h40, 8'h40, 6, 0);
    step("rel_all",     0, 1, 2'b00, 9, 8'h00, 8'h00, 6, 0);
    step("idle_hold",   0, 1, 2'b00, 9, 8'h00, 8'h00, 6, 0);

    // reset mid-RUN, then a single held key
    step("rst_enter", 0, 1, 2'b00, 5, 8'h48, 8'h08, 3, 1);
    step("rst_cnt",   0, 1, 2'b00, 5, 8'h48, 8'h08, 3, 0);
    step("rst_mid",   1, 1, 2'b00, 5, 8'h48, 8'h00, 0, 0);
    step("single_enter", 0, 1, 2'b00, 2, 8'h10, 8'h10, 4, 1);
    for (int c = 0; c < 8; c++) begin
      step("single_steady", 0, 1, 2'b00, 2, 8'h10, 8'h10, 4, 0);
    end

    // simultaneous release of the current key and step expiry: one advance
    step("sim_dis",     0, 0, 2'b00, 1, 8'h00, 8'h00, 4, 0);
    step("sim_enter",   0, 1, 2'b00, 1, 8'h24, 8'h04, 2, 1);
    step("sim_cnt",     0, 1, 2'b00, 1, 8'h24, 8'h04, 2, 0);
    step("sim_rel_exp", 0, 1, 2'b00, 1, 8'h20, 8'h20, 5, 1);
    step("sim_after",   0, 1, 2'b00, 1, 8'h20, 8'h20, 5, 0);
    step("sim_solo",    0, 1, 2'b00, 1, 8'h20, 8'h20, 5, 0);

    // step_time lowered below the running count advances on the next edge
    step("st_dis",   0, 0, 2'b00, 9, 8'h00, 8'h00, 5, 0);
    step("st_enter", 0, 1, 2'b00, 9, 8'h24, 8'h04, 2, 1);
    for (int c = 0; c < 3; c++) begin
      step("st_cnt", 0, 1, 2'b00, 9, 8'h24, 8'h04, 2, 0);
    end
    step("st_shrink", 0, 1, 2'b00, 1, 8'h24, 8'h20, 5, 1);
    step("st_after",  0, 1, 2'b00, 1, 8'h24, 8'h20, 5, 0);

    // mode 11 behaves as up; disabling mid-RUN passes keys through
    step("m3_dis",   0, 0, 2'b11, 0, 8'h00, 8'h00, 5, 0);
    step("m3_enter", 0, 1, 2'b11, 0, 8'h81, 8'h01, 0, 1);
    step("m3_adv",   0, 1, 2'b11, 0, 8'h81, 8'h80, 7, 1);
    step("m3_wrap",  0, 1, 2'b11, 0, 8'h81, 8'h01, 0, 1);
    step("dis_run",  0, 0, 2'b11, 0, 8'h81, 8'h81, 0, 0);

    if (sb.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
